// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter with configurable data width, parity and stop bits.
// Frames are sent back to back while the write FIFO holds characters.
module uart_tx_buffered #(
   parameter int unsigned CLOCK_FREQ = 12000000,
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [DATA_BITS-1:0]          write_data,
   input  logic                          write_enable,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic                          busy,
   output logic                          tx,
   output logic                          uart_clock
);

   localparam int unsigned DIV = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned LW  = AW + 1;
   localparam logic [CW-1:0] CntMax   = CW'(DIV - 1);
   localparam logic [3:0]    BitLast  = 4'(DATA_BITS - 1);
   localparam logic [3:0]    StopLast = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]        r_level, w_level_d;
   logic                 r_full, r_empty, r_overflow;
   logic                 w_push, w_pop;
   logic [DATA_BITS-1:0] w_head;
   logic                 w_head_par;

   state_t               r_state, w_state_d;
   logic [CW-1:0]        r_cnt, w_cnt_d;
   logic [3:0]           r_bit, w_bit_d;
   logic [DATA_BITS-1:0] r_shift, w_shift_d;
   logic                 r_par, w_par_d;
   logic                 r_tx, w_tx_d;
   logic                 r_busy, w_busy_d;
   logic                 r_uck, w_uck_d;
   logic                 w_bit_end, w_load;

   // Fullness is judged before any same-edge pop, so a write while full is always dropped.
   assign w_push     = write_enable & ~r_full;
   assign w_head     = r_mem[r_rd_ptr];
   assign w_head_par = (PARITY == 1) ? ~(^w_head) : (^w_head);

   always_comb begin
      w_level_d = r_level;
      unique case ({w_push, w_pop})
         2'b10:   w_level_d = r_level + 1'b1;
         2'b01:   w_level_d = r_level - 1'b1;
         default: w_level_d = r_level;
      endcase
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= write_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level    <= w_level_d;
         r_full     <= (w_level_d == LW'(FIFO_DEPTH));
         r_empty    <= (w_level_d == '0);
         r_overflow <= write_enable & r_full;
      end
   end

   assign w_bit_end = (r_cnt == CntMax);

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = w_bit_end ? '0 : r_cnt + 1'b1;
      w_bit_d   = r_bit;
      w_shift_d = r_shift;
      w_par_d   = r_par;
      w_tx_d    = r_tx;
      w_busy_d  = r_busy;
      w_pop     = 1'b0;
      w_load    = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_cnt_d = '0;
            w_tx_d  = 1'b1;
            w_load  = ~r_empty;
         end
         StStart: begin
            if (w_bit_end) begin
               w_state_d = StData;
               w_tx_d    = r_shift[0];
               w_shift_d = {1'b0, r_shift[DATA_BITS-1:1]};
               w_bit_d   = '0;
            end
         end
         StData: begin
            if (w_bit_end) begin
               if (r_bit == BitLast) begin
                  w_bit_d = '0;
                  if (PARITY != 0) begin
                     w_state_d = StParity;
                     w_tx_d    = r_par;
                  end else begin
                     w_state_d = StStop;
                     w_tx_d    = 1'b1;
                  end
               end else begin
                  w_bit_d   = r_bit + 4'd1;
                  w_tx_d    = r_shift[0];
                  w_shift_d = {1'b0, r_shift[DATA_BITS-1:1]};
               end
            end
         end
         StParity: begin
            if (w_bit_end) begin
               w_state_d = StStop;
               w_tx_d    = 1'b1;
               w_bit_d   = '0;
            end
         end
         StStop: begin
            if (w_bit_end) begin
               if (r_bit == StopLast) begin
                  if (!r_empty) begin
                     w_load = 1'b1;
                  end else begin
                     w_state_d = StIdle;
                     w_busy_d  = 1'b0;
                     w_tx_d    = 1'b1;
                  end
               end else begin
                  w_bit_d = r_bit + 4'd1;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
      // Loading from the FIFO starts a frame directly, with no idle cycle after a stop bit.
      if (w_load) begin
         w_pop     = 1'b1;
         w_state_d = StStart;
         w_shift_d = w_head;
         w_par_d   = w_head_par;
         w_tx_d    = 1'b0;
         w_busy_d  = 1'b1;
         w_cnt_d   = '0;
      end
      w_uck_d = (w_state_d != StIdle) && (w_cnt_d == CntMax);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_uck   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_bit   <= w_bit_d;
         r_shift <= w_shift_d;
         r_par   <= w_par_d;
         r_tx    <= w_tx_d;
         r_busy  <= w_busy_d;
         r_uck   <= w_uck_d;
      end
   end

   assign full       = r_full;
   assign empty      = r_empty;
   assign level      = r_level;
   assign overflow   = r_overflow;
   assign busy       = r_busy;
   assign tx         = r_tx;
   assign uart_clock = r_uck;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: four instances (8N1/depth 4, 8E1, 8O1, 7N2), DIV=4.
// Expected frames are queued at write time; a line monitor decodes tx and compares.
module tb_uart_tx_buffered;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] we;
   logic [8:0] wd;
   logic [3:0] tx, busy, uck, full, empty, ovf;
   logic [2:0] lvl_a;
   logic [4:0] lvl_b, lvl_c, lvl_d;
   logic [1:0] sel;
   logic       mon_en;
   logic       tx_sel, busy_sel, uck_sel;

   typedef struct {
      logic [11:0] bits;
      int          n;
   } exp_t;
   exp_t q[$];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   assign tx_sel   = tx[sel];
   assign busy_sel = busy[sel];
   assign uck_sel  = uck[sel];

   uart_tx_buffered #(.CLOCK_FREQ(4800), .BAUD_RATE(1200), .DATA_BITS(8), .PARITY(0),
                      .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
      .clock(clk), .reset(rst), .write_data(wd[7:0]), .write_enable(we[0]), .full(full[0]),
      .empty(empty[0]), .level(lvl_a), .overflow(ovf[0]), .busy(busy[0]), .tx(tx[0]),
      .uart_clock(uck[0]));

   uart_tx_buffered #(.CLOCK_FREQ(4800), .BAUD_RATE(1200), .DATA_BITS(8), .PARITY(2),
                      .STOP_BITS(1), .FIFO_DEPTH(16)) u_b (
      .clock(clk), .reset(rst), .write_data(wd[7:0]), .write_enable(we[1]), .full(full[1]),
      .empty(empty[1]), .level(lvl_b), .overflow(ovf[1]), .busy(busy[1]), .tx(tx[1]),
      .uart_clock(uck[1]));

   uart_tx_buffered #(.CLOCK_FREQ(4800), .BAUD_RATE(1200), .DATA_BITS(8), .PARITY(1),
                      .STOP_BITS(1), .FIFO_DEPTH(16)) u_c (
      .clock(clk), .reset(rst), .write_data(wd[7:0]), .write_enable(we[2]), .full(full[2]),
      .empty(empty[2]), .level(lvl_c), .overflow(ovf[2]), .busy(busy[2]), .tx(tx[2]),
      .uart_clock(uck[2]));

   uart_tx_buffered #(.CLOCK_FREQ(4800), .BAUD_RATE(1200), .DATA_BITS(7), .PARITY(0),
                      .STOP_BITS(2), .FIFO_DEPTH(16)) u_d (
      .clock(clk), .reset(rst), .write_data(wd[6:0]), .write_enable(we[3]), .full(full[3]),
      .empty(empty[3]), .level(lvl_d), .overflow(ovf[3]), .busy(busy[3]), .tx(tx[3]),
      .uart_clock(uck[3]));

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
   endtask

   task automatic push(input logic [11:0] bits, input int n);
      exp_t e;
      e.bits = bits;
      e.n    = n;
      q.push_back(e);
   endtask

   task automatic wr(input int id, input logic [8:0] d);
      wd     = d;
      we[id] = 1'b1;
      @(posedge clk); #1;
      we[id] = 1'b0;
   endtask

   // Waits for busy, then counts busy cycles and uart_clock pulses of the selected instance.
   task automatic measure(output int bc, output int uc);
      int t;
      t  = 0;
      bc = 0;
      uc = 0;
      while (!busy_sel && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      while (busy_sel && bc < 2000) begin
         if (uck_sel) uc++;
         bc++;
         @(posedge clk); #1;
      end
   endtask

   // Line monitor: start bit detected at a negedge, then one sample per bit period.
   initial begin
      exp_t        e;
      logic [11:0] got;
      forever begin
         @(negedge clk);
         if (mon_en && !rst && !tx_sel) begin
            if (q.size() == 0) begin
               check("unexpected_frame", 1, 0);
               repeat (44) @(negedge clk);
            end else begin
               e      = q.pop_front();
               got    = '0;
               got[0] = tx_sel;
               for (int i = 1; i < e.n; i++) begin
                  repeat (4) @(negedge clk);
                  got[i] = tx_sel;
               end
               check("frame", int'(got), int'(e.bits));
            end
         end
      end
   end

   initial begin
      int          bc, uc, t, lows, bz;
      logic [7:0]  fdata [6];
      logic [11:0] fbits [5];
      int          exp_lv [6];

      fdata  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      fbits  = '{12'h222, 12'h244, 12'h266, 12'h288, 12'h2AA};
      exp_lv = '{1, 1, 2, 3, 4, 4};
      we     = '0;
      wd     = '0;
      sel    = 2'd0;
      mon_en = 1'b1;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_tx", tx[0], 1);
      check("rst_busy", busy[0], 0);
      check("rst_empty", empty[0], 1);
      check("rst_full", full[0], 0);
      check("rst_level", lvl_a, 0);
      check("rst_overflow", ovf[0], 0);
      check("rst_uart_clock", uck[0], 0);
      @(posedge clk); #1;

      // 8N1 single character 0x60
      push(12'h2C0, 10);
      wr(0, 9'h060);
      measure(bc, uc);
      check("8n1_busy_cycles", bc, 40);
      check("8n1_uart_clocks", uc, 10);
      repeat (5) @(posedge clk); #1;

      // Back-to-back 0x41, 0x42 with no idle gap
      push(12'h282, 10);
      push(12'h284, 10);
      wd    = 9'h041;
      we[0] = 1'b1;
      @(posedge clk); #1;
      wd    = 9'h042;
      @(posedge clk); #1;
      we[0] = 1'b0;
      measure(bc, uc);
      check("b2b_busy_cycles", bc, 80);
      check("b2b_uart_clocks", uc, 20);
      repeat (5) @(posedge clk); #1;

      // Even parity
      sel = 2'd1;
      push(12'h4C0, 11);
      wr(1, 9'h060);
      measure(bc, uc);
      check("8e1_busy_cycles", bc, 44);
      check("8e1_uart_clocks", uc, 11);
      repeat (5) @(posedge clk); #1;

      // Odd parity
      sel = 2'd2;
      push(12'h6C0, 11);
      wr(2, 9'h060);
      measure(bc, uc);
      check("8o1_busy_cycles", bc, 44);
      check("8o1_uart_clocks", uc, 11);
      repeat (5) @(posedge clk); #1;

      // 7 data bits, two stop bits
      sel = 2'd3;
      push(12'h3AA, 10);
      wr(3, 9'h055);
      measure(bc, uc);
      check("7n2_busy_cycles", bc, 40);
      check("7n2_uart_clocks", uc, 10);
      repeat (5) @(posedge clk); #1;

      // FIFO fill and overflow on depth-4 instance
      sel   = 2'd0;
      we[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wd = {1'b0, fdata[i]};
         if (i < 5) push(fbits[i], 10);
         @(posedge clk); #1;
         check("fifo_level", lvl_a, exp_lv[i]);
         check("fifo_full", full[0], (i >= 4) ? 1 : 0);
         check("fifo_overflow", ovf[0], (i == 5) ? 1 : 0);
      end
      we[0] = 1'b0;
      @(posedge clk); #1;
      check("overflow_one_cycle", ovf[0], 0);
      t = 0;
      while (busy[0] && t < 1000) begin
         @(posedge clk); #1;
         t++;
      end
      check("fifo_drain_in_time", (t < 1000) ? 1 : 0, 1);
      repeat (5) @(posedge clk); #1;
      check("scoreboard_empty", q.size(), 0);

      // Mid-frame reset with three characters written
      mon_en = 1'b0;
      we[0]  = 1'b1;
      wd     = 9'h001;
      @(posedge clk); #1;
      wd     = 9'h002;
      @(posedge clk); #1;
      wd     = 9'h003;
      @(posedge clk); #1;
      we[0]  = 1'b0;
      check("pre_reset_level", lvl_a, 2);
      repeat (13) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("reset_async_tx", tx[0], 1);
      check("reset_busy", busy[0], 0);
      check("reset_level", lvl_a, 0);
      check("reset_empty", empty[0], 1);
      @(posedge clk); #1;
      rst  = 1'b0;
      lows = 0;
      bz   = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (!tx[0]) lows++;
         if (busy[0]) bz++;
      end
      check("post_reset_tx_low", lows, 0);
      check("post_reset_busy", bz, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised, FIFO-buffered UART transmitter; next generation of `uart_tx`. Adds configurable data width, parity and stop bits, plus an internal write FIFO so producers push characters without waiting on `ready` per byte. Sits between any byte producer (e.g. an LPC capture formatter) and the board's TX pin.

## Interface

Parameters:
- CLOCK_FREQ, 12000000, clock frequency in Hz
- BAUD_RATE, 115200, line rate; DIV = CLOCK_FREQ/BAUD_RATE (integer division), DIV ≥ 2 required
- DATA_BITS, 8, character width, legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 16, entries, power of two ≥ 2

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- write_data  in  DATA_BITS  character to enqueue
- write_enable  in  1  enqueue request, sampled each rising edge
- full  out  1  FIFO holds FIFO_DEPTH entries
- empty  out  1  FIFO holds 0 entries
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  one-cycle pulse: write attempted while full
- busy  out  1  frame in progress
- tx  out  1  serial line, idles high
- uart_clock  out  1  one-cycle pulse at each bit boundary

## Operation

- Reset values: tx=1, busy=0, empty=1, full=0, level=0, overflow=0, uart_clock=0; FIFO flushed, baud counter 0, FSM IDLE.
- Write accepted on edge where write_enable=1 and full=0. Write with full=1 is dropped, FIFO unchanged, overflow=1 for the following cycle. full is evaluated before any same-cycle pop: a write while full is rejected even if a pop occurs on that edge.
- level: +1 on accepted write, −1 on pop, unchanged when both occur on the same edge. full/empty derived from level and always consistent with it.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If empty=0, pop head into shift register, go START, busy=1, baud counter cleared.
  - START: tx=0 for DIV cycles → DATA.
  - DATA: DATA_BITS bits, LSB first, DIV cycles each → PARITY if PARITY≠0, else STOP.
  - PARITY: odd: XOR of data bits inverted; even: XOR of data bits; DIV cycles → STOP.
  - STOP: tx=1 for STOP_BITS×DIV cycles. At completion: if empty=0, pop and go START on the same edge (no idle gap); else go IDLE, busy=0.
- Baud counter counts 0..DIV−1 within each bit; uart_clock=1 on the cycle the counter equals DIV−1.
- Frame length = DIV × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously), queued data discarded, no partial frame resumes.

## Timing

- tx, busy, uart_clock, overflow, full, empty, level all registered.
- Write into empty FIFO while IDLE at edge k: empty=0 after k. At edge k+1: pop, tx=0, busy=1. Start-bit latency is one cycle.
- Each bit holds exactly DIV cycles. busy stays high continuously across back-to-back frames.
- An accepted write never reaches tx before the preceding frame's final stop bit ends.

## Test plan

- CLOCK_FREQ=4800, BAUD_RATE=1200 (DIV=4), 8N1, write 0x60 once → tx sequence 0,0,0,0,0,0,1,1,0,1, each held 4 cycles; busy high for 40 cycles; 10 uart_clock pulses.
- Same, PARITY=2 then PARITY=1, write 0x60 → parity bit 0 (even), 1 (odd); frame 44 cycles.
- FIFO_DEPTH=4, six writes on consecutive edges k..k+5 → level 1,1,2,3,4 then full=1; sixth write dropped, overflow pulses once after edge k+5; exactly five frames emitted, in order.
- Two writes 0x41, 0x42 → two contiguous 40-cycle frames, tx never idles between stop bit and second start bit, busy high for 80 cycles.
- Assert reset for 1 cycle at cycle 15 of a frame with 3 bytes queued → tx=1 immediately, busy=0, level=0, empty=1; no further frames.
- DATA_BITS=7, STOP_BITS=2, PARITY=0, write 0x55 → 1,0,1,0,1,0,1 after start, stop held 8 cycles; frame 40 cycles.
